// File: rtl/rvc_fetch_aligner_if.sv
// Fetch-side and decode-side handshake bundle for the RVC fetch aligner.
// The aligner connects through the slave modport; the fetch/decode
// environment drives through the master modport.
interface rvc_fetch_aligner_if #(
  parameter int PC_W = 32
);
  logic            f_valid;
  logic            f_ready;
  logic [31:0]     f_data;
  logic            redir_valid;
  logic [PC_W-1:0] redir_pc;
  logic            o_valid;
  logic            o_ready;
  logic [31:0]     o_inst;
  logic [PC_W-1:0] o_pc;
  logic            o_is_c;
  logic            o_ill;

  modport master (
    output f_valid, f_data, redir_valid, redir_pc, o_ready,
    input  f_ready, o_valid, o_inst, o_pc, o_is_c, o_ill
  );

  modport slave (
    input  f_valid, f_data, redir_valid, redir_pc, o_ready,
    output f_ready, o_valid, o_inst, o_pc, o_is_c, o_ill
  );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// RVC fetch aligner: buffers up to three halfwords from word-aligned fetch
// data, reassembles 32-bit instructions that straddle fetch words, expands
// compressed instructions to RV32I and presents one instruction per cycle.
module rvc_fetch_aligner #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int              EXPAND   = 1
) (
  input logic                clk,
  input logic                rst_n,
  rvc_fetch_aligner_if.slave bus
);

  localparam logic [31:0] NOP = 32'h00000013;

  // Expand one compressed halfword; result is {ill, inst}.
  function automatic logic [32:0] expand_rvc(input logic [15:0] c);
    logic [31:0] inst;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rdp;
    logic [4:0]  rs1p;
    logic [11:0] imm6;
    logic [11:0] mem_off;
    logic [20:0] j_off;
    logic [12:0] b_off;
    rd      = c[11:7];
    rs2     = c[6:2];
    rdp     = {2'b01, c[4:2]};
    rs1p    = {2'b01, c[9:7]};
    imm6    = {{6{c[12]}}, c[12], c[6:2]};
    mem_off = {5'b00000, c[5], c[12:10], c[6], 2'b00};
    j_off   = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    b_off   = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    ill     = 1'b0;
    inst    = NOP;
    case ({c[1:0], c[15:13]})
      5'b00_010: inst = {mem_off, rs1p, 3'b010, rdp, 7'b0000011};                       // c.lw
      5'b00_110: inst = {mem_off[11:5], rdp, rs1p, 3'b010, mem_off[4:0], 7'b0100011};   // c.sw
      5'b01_000: inst = {imm6, rd, 3'b000, rd, 7'b0010011};                             // c.addi / c.nop
      5'b01_001: inst = {j_off[20], j_off[10:1], j_off[11], j_off[19:12], 5'd1, 7'b1101111}; // c.jal
      5'b01_010: inst = {imm6, 5'd0, 3'b000, rd, 7'b0010011};                           // c.li
      5'b01_011: begin                                                                  // c.lui
        if ((rd == 5'd0) || (rd == 5'd2) || ({c[12], c[6:2]} == 6'd0)) begin
          ill = 1'b1;
        end else begin
          inst = {{14{c[12]}}, c[12], c[6:2], rd, 7'b0110111};
        end
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: begin                                                                  // c.srli
            if (c[12]) ill = 1'b1;
            else       inst = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
          end
          2'b01: begin                                                                  // c.srai
            if (c[12]) ill = 1'b1;
            else       inst = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
          end
          2'b10: inst = {imm6, rs1p, 3'b111, rs1p, 7'b0010011};                         // c.andi
          2'b11: begin
            if (c[12]) begin
              ill = 1'b1;
            end else begin
              case (c[6:5])
                2'b00:   inst = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0110011};     // c.sub
                2'b01:   inst = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'b0110011};     // c.xor
                2'b10:   inst = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'b0110011};     // c.or
                2'b11:   inst = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'b0110011};     // c.and
                default: ill = 1'b1;
              endcase
            end
          end
          default: ill = 1'b1;
        endcase
      end
      5'b01_101: inst = {j_off[20], j_off[10:1], j_off[11], j_off[19:12], 5'd0, 7'b1101111}; // c.j
      5'b01_110: inst = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b000, b_off[4:1], b_off[11], 7'b1100011}; // c.beqz
      5'b01_111: inst = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b001, b_off[4:1], b_off[11], 7'b1100011}; // c.bnez
      5'b10_000: begin                                                                  // c.slli
        if (c[12]) ill = 1'b1;
        else       inst = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'b0010011};
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 != 5'd0)     inst = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'b0110011};  // c.mv
          else if (rd != 5'd0) inst = {12'h000, rd, 3'b000, 5'd0, 7'b1100111};          // c.jr
          else                 ill  = 1'b1;
        end else begin
          if (rs2 != 5'd0)     inst = {7'b0000000, rs2, rd, 3'b000, rd, 7'b0110011};    // c.add
          else if (rd != 5'd0) inst = {12'h000, rd, 3'b000, 5'd1, 7'b1100111};          // c.jalr
          else                 ill  = 1'b1;                                              // c.ebreak unsupported
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) inst = NOP;
    else     inst = inst;
    return {ill, inst};
  endfunction

  logic [2:0][15:0] buf_r;
  logic [1:0]       count_r;
  logic [PC_W-1:0]  pc_r;
  logic             skip_r;

  logic [2:0][15:0] buf_n;
  logic [1:0]       count_n;
  logic [PC_W-1:0]  pc_n;
  logic             skip_n;

  logic             head_c_s;
  logic             valid_s;
  logic             ready_s;
  logic             accept_s;
  logic             fire_s;
  logic [1:0]       consume_s;
  logic [1:0]       base_s;
  logic [2:0][15:0] shifted_s;
  logic [32:0]      exp_s;

  // Handshake decode and output presentation from the registered buffer.
  always_comb begin
    head_c_s = (buf_r[0][1:0] != 2'b11);
    if (head_c_s) valid_s = (count_r >= 2'd1);
    else          valid_s = (count_r >= 2'd2);
    ready_s  = (count_r <= 2'd1) && !bus.redir_valid;
    accept_s = bus.f_valid && ready_s;
    fire_s   = valid_s && bus.o_ready && !bus.redir_valid;
    if (!fire_s)       consume_s = 2'd0;
    else if (head_c_s) consume_s = 2'd1;
    else               consume_s = 2'd2;
    if (EXPAND != 0) exp_s = expand_rvc(buf_r[0]);
    else             exp_s = {1'b1, 16'h0000, buf_r[0]};
    bus.f_ready = ready_s;
    bus.o_valid = valid_s;
    bus.o_pc    = pc_r;
    bus.o_is_c  = head_c_s;
    if (head_c_s) begin
      bus.o_inst = exp_s[31:0];
      bus.o_ill  = exp_s[32];
    end else begin
      bus.o_inst = {buf_r[1], buf_r[0]};
      bus.o_ill  = 1'b0;
    end
  end

  // Next buffer state: redirect flush, else shift out consumed halfwords then append.
  always_comb begin
    base_s = count_r - consume_s;
    case (consume_s)
      2'd0:    shifted_s = buf_r;
      2'd1:    shifted_s = {16'h0000, buf_r[2], buf_r[1]};
      2'd2:    shifted_s = {32'h00000000, buf_r[2]};
      default: shifted_s = buf_r;
    endcase
    buf_n   = shifted_s;
    count_n = base_s;
    pc_n    = pc_r + PC_W'({consume_s, 1'b0});
    skip_n  = skip_r;
    if (bus.redir_valid) begin
      count_n = 2'd0;
      pc_n    = bus.redir_pc & {{(PC_W-1){1'b1}}, 1'b0};
      skip_n  = bus.redir_pc[1];
    end else if (accept_s) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) == base_s)                          buf_n[i] = skip_r ? bus.f_data[31:16] : bus.f_data[15:0];
        else if (!skip_r && (2'(i) == base_s + 2'd1)) buf_n[i] = bus.f_data[31:16];
        else                                          buf_n[i] = shifted_s[i];
      end
      count_n = base_s + (skip_r ? 2'd1 : 2'd2);
      skip_n  = 1'b0;
    end else begin
      count_n = base_s;
    end
  end

  // Buffer, count, head PC and skip flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r   <= '0;
      count_r <= 2'd0;
      pc_r    <= RESET_PC;
      skip_r  <= RESET_PC[1];
    end else begin
      buf_r   <= buf_n;
      count_r <= count_n;
      pc_r    <= pc_n;
      skip_r  <= skip_n;
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed, table-driven bench for rvc_fetch_aligner plus hand-written
// reset sequences.
module tb_rvc_fetch_aligner;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        fv;
    logic [31:0] fd;
    logic        ordy;
    logic        ev;
    logic [31:0] einst;
    logic [31:0] epc;
    logic        ec;
    logic        eill;
    logic        efr;
  } vec_t;

  localparam int N_VEC = 38;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t tbl [N_VEC];

  rvc_fetch_aligner_if #(.PC_W(32)) bus ();

  rvc_fetch_aligner #(.PC_W(32), .RESET_PC(32'h0), .EXPAND(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic rv, input logic [31:0] rpc, input logic fv,
                             input logic [31:0] fd, input logic ordy, input logic ev,
                             input logic [31:0] einst, input logic [31:0] epc,
                             input logic ec, input logic eill, input logic efr);
    vec_t t;
    t.rv = rv; t.rpc = rpc; t.fv = fv; t.fd = fd; t.ordy = ordy;
    t.ev = ev; t.einst = einst; t.epc = epc; t.ec = ec; t.eill = eill; t.efr = efr;
    return t;
  endfunction

  task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b f_ready=%0b inst=%08h pc=%08h is_c=%0b ill=%0b, expected valid=%0b f_ready=%0b inst=%08h pc=%08h is_c=%0b ill=%0b",
               name, got[67], got[66], got[65:34], got[33:2], got[1], got[0],
               exp[67], exp[66], exp[65:34], exp[33:2], exp[1], exp[0]);
    end
  endtask

  task automatic run_vec(input vec_t t, input string name);
    logic [67:0] got;
    logic [67:0] exp;
    @(negedge clk);
    bus.redir_valid = t.rv;
    bus.redir_pc    = t.rpc;
    bus.f_valid     = t.fv;
    bus.f_data      = t.fd;
    bus.o_ready     = t.ordy;
    #1;
    got = {bus.o_valid, bus.f_ready, bus.o_inst, bus.o_pc, bus.o_is_c, bus.o_ill};
    exp = {t.ev, t.efr, t.einst, t.epc, t.ec, t.eill};
    if (!t.ev) begin
      got[65:0] = '0;
      exp[65:0] = '0;
    end
    check(name, got, exp);
  endtask

  task automatic idle_inputs();
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;
    bus.f_valid     = 1'b0;
    bus.f_data      = 32'h0;
    bus.o_ready     = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();

    // rv rpc fv fd ordy | ev inst pc is_c ill f_ready
    tbl[0]  = v(1'b1, 32'h100, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b0);
    tbl[1]  = v(1'b0, 32'h0,   1'b1, 32'h05054505, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    tbl[2]  = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00100513, 32'h100, 1'b1, 1'b0, 1'b0);
    tbl[3]  = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00150513, 32'h102, 1'b1, 1'b0, 1'b1);
    tbl[4]  = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    // straddling 32-bit instruction
    tbl[5]  = v(1'b1, 32'h200, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b0);
    tbl[6]  = v(1'b0, 32'h0,   1'b1, 32'h05134505, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    tbl[7]  = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00100513, 32'h200, 1'b1, 1'b0, 1'b0);
    tbl[8]  = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    tbl[9]  = v(1'b0, 32'h0,   1'b1, 32'hFFFF0010, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    tbl[10] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00100513, 32'h202, 1'b0, 1'b0, 1'b0);
    // redirect to a halfword target while two halfwords are buffered
    tbl[11] = v(1'b1, 32'h300, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b0);
    tbl[12] = v(1'b0, 32'h0,   1'b1, 32'h05054505, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    tbl[13] = v(1'b1, 32'h303, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h00100513, 32'h300, 1'b1, 1'b0, 1'b0);
    tbl[14] = v(1'b0, 32'h0,   1'b1, 32'h4505BEEF, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    tbl[15] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00100513, 32'h302, 1'b1, 1'b0, 1'b1);
    // backpressure with a full buffer
    tbl[16] = v(1'b0, 32'h0,   1'b1, 32'h4108852E, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    tbl[17] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00B00533, 32'h304, 1'b1, 1'b0, 1'b0);
    tbl[18] = v(1'b0, 32'h0,   1'b1, 32'h00000000, 1'b0, 1'b1, 32'h00052503, 32'h306, 1'b1, 1'b0, 1'b1);
    tbl[19] = v(1'b0, 32'h0,   1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00052503, 32'h306, 1'b1, 1'b0, 1'b0);
    tbl[20] = v(1'b0, 32'h0,   1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00052503, 32'h306, 1'b1, 1'b0, 1'b0);
    tbl[21] = v(1'b0, 32'h0,   1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00052503, 32'h306, 1'b1, 1'b0, 1'b0);
    tbl[22] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00052503, 32'h306, 1'b1, 1'b0, 1'b0);
    tbl[23] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00000013, 32'h308, 1'b1, 1'b1, 1'b0);
    tbl[24] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00000013, 32'h30A, 1'b1, 1'b1, 1'b1);
    tbl[25] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    // streaming expansion patterns: c.sw, c.lui, c.lui neg, c.beqz, c.jal, c.srai, c.sub, c.lwsp(ill), c.jalr, c.lw
    tbl[26] = v(1'b0, 32'h0,   1'b1, 32'h6505C14C, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);
    tbl[27] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00B52223, 32'h30C, 1'b1, 1'b0, 1'b0);
    tbl[28] = v(1'b0, 32'h0,   1'b1, 32'hDD7D757D, 1'b1, 1'b1, 32'h00001537, 32'h30E, 1'b1, 1'b0, 1'b1);
    tbl[29] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFF537, 32'h310, 1'b1, 1'b0, 1'b0);
    tbl[30] = v(1'b0, 32'h0,   1'b1, 32'h850D2021, 1'b1, 1'b1, 32'hFE050FE3, 32'h312, 1'b1, 1'b0, 1'b1);
    tbl[31] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h008000EF, 32'h314, 1'b1, 1'b0, 1'b0);
    tbl[32] = v(1'b0, 32'h0,   1'b1, 32'h45028D0D, 1'b1, 1'b1, 32'h40355513, 32'h316, 1'b1, 1'b0, 1'b1);
    tbl[33] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h40B50533, 32'h318, 1'b1, 1'b0, 1'b0);
    tbl[34] = v(1'b0, 32'h0,   1'b1, 32'h41089502, 1'b1, 1'b1, 32'h00000013, 32'h31A, 1'b1, 1'b1, 1'b1);
    tbl[35] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h000500E7, 32'h31C, 1'b1, 1'b0, 1'b0);
    tbl[36] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00052503, 32'h31E, 1'b1, 1'b0, 1'b1);
    tbl[37] = v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1);

    // reset state while rst_n is held low
    #12;
    check("reset_state", {bus.o_valid, bus.f_ready, 32'h0, bus.o_pc, 2'b00},
                         {1'b0, 1'b1, 32'h0, 32'h0, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N_VEC; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset in the middle of a straddling instruction
    run_vec(v(1'b1, 32'h400, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b0), "strad_redir");
    run_vec(v(1'b0, 32'h0,   1'b1, 32'h05134505, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1), "strad_word");
    run_vec(v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00100513, 32'h400, 1'b1, 1'b0, 1'b0), "strad_cli");
    run_vec(v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1), "strad_wait");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_straddle", {bus.o_valid, bus.f_ready, 32'h0, bus.o_pc, 2'b00},
                              {1'b0, 1'b1, 32'h0, 32'h0, 2'b00});
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(v(1'b0, 32'h0,   1'b1, 32'h05054505, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1), "post_rst_word");
    run_vec(v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00100513, 32'h000, 1'b1, 1'b0, 1'b0), "post_rst_i0");
    run_vec(v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00150513, 32'h002, 1'b1, 1'b0, 1'b1), "post_rst_i1");
    run_vec(v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1), "post_rst_empty");

    // asynchronous reset while an instruction is being presented
    run_vec(v(1'b0, 32'h0,   1'b1, 32'h05054505, 1'b0, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1), "hold_word");
    run_vec(v(1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b1, 32'h00100513, 32'h004, 1'b1, 1'b0, 1'b0), "hold_valid");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_while_valid", {bus.o_valid, bus.f_ready, 32'h0, bus.o_pc, 2'b00},
                             {1'b0, 1'b1, 32'h0, 32'h0, 2'b00});
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(v(1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1), "rst_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
